instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 102 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues sequential fetch addresses to a one-cycle
// memory, buffers the returned words in a 2-entry FIFO and supports redirects.
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00400000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_instr_i,
  input  logic                  branch_taken_i,
  input  logic [DATA_WIDTH-1:0] branch_target_i,
  input  logic                  instr_ready_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] pcs_q  [2];

  logic       pop, push, issue, tail;
  logic [2:0] occupancy;

  assign instr_valid_o = (count_q != 2'd0);
  assign pop           = instr_valid_o & instr_ready_i;
  assign push          = inflight_q & ~branch_taken_i;
  // Slots already committed (buffered plus returning) after this cycle's pop.
  assign occupancy     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue         = ~branch_taken_i & (occupancy < 3'd2);
  assign tail          = head_q ^ count_q[0];

  assign mem_addr_o = fpc_q;
  assign instr_o    = data_q[head_q];
  assign pc_o       = pcs_q[head_q];
  assign pc_plus4_o = pc_o + FOUR;

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    if (branch_taken_i) begin
      fpc_d      = {branch_target_i[DATA_WIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fpc_d         = fpc_q + FOUR;
        inflight_pc_d = fpc_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      // NOTE: the buffer is only two entries, so clearing it on reset is cheap
      // and gives defined instr_o/pc_o values straight out of reset.
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      if (push) begin
        data_q[tail] <= mem_instr_i;
        pcs_q[tail]  <= inflight_pc_q;
      end
    end
  end

`ifndef SYNTHESIS
  // The issue rule must keep a returning word from ever finding the buffer full.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && count_q == 2'd2 && !pop));
`endif

endmodule
